// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - state, opcode and mux-select encodings for the multicycle controller
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_JAL,
    S_ALUWB,
    S_BEQ
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

endpackage

// File: rtl/ctrl_main_fsm.sv
// rtl/ctrl_main_fsm.sv - state register, next-state logic and raw Moore outputs
module ctrl_main_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       pc_update,
  output logic       branch,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       mem_req,
  output logic       illegal,
  output logic       retire,
  output logic       wait_mem
);

  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // wait_mem marks strobes that must only fire on the cycle the memory completes
  always_comb begin
    state_next = state;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    alu_op     = ALUOP_ADD;
    mem_req    = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;
    wait_mem   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        ir_write   = 1'b1;
        pc_update  = 1'b1;
        wait_mem   = 1'b1;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECR;
          OP_IALU:      state_next = S_EXECI;
          OP_JAL:       state_next = S_JAL;
          OP_BRANCH:    state_next = S_BEQ;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_req   = 1'b1;
        mem_write = 1'b1;
        retire    = 1'b1;
        wait_mem  = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_FUNC;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNC;
        state_next = S_ALUWB;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RISC-V control sequencer with branch and handshake glue
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       mem_req,
  output logic       illegal,
  output logic       retire
);

  logic       pc_update, branch, ir_write_raw, adr_src_raw, mem_write_raw, reg_write_raw;
  logic       mem_req_raw, illegal_raw, retire_raw, wait_mem;
  logic [1:0] alu_src_a_raw, alu_src_b_raw, result_src_raw, alu_op_raw;
  logic       taken, strobe_ok, run;
  logic       unused_funct3;

  ctrl_main_fsm u_fsm (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .mem_ready  (mem_ready),
    .pc_update  (pc_update),
    .branch     (branch),
    .ir_write   (ir_write_raw),
    .adr_src    (adr_src_raw),
    .mem_write  (mem_write_raw),
    .reg_write  (reg_write_raw),
    .alu_src_a  (alu_src_a_raw),
    .alu_src_b  (alu_src_b_raw),
    .result_src (result_src_raw),
    .alu_op     (alu_op_raw),
    .mem_req    (mem_req_raw),
    .illegal    (illegal_raw),
    .retire     (retire_raw),
    .wait_mem   (wait_mem)
  );

  assign unused_funct3 = ^funct3[2:1];
  assign taken     = zero ^ funct3[0];
  assign strobe_ok = ~wait_mem | mem_ready;
  // Reset forces every output low so an aborted instruction cannot write anything
  assign run       = ~rst;

  assign pc_write   = run & ((pc_update & strobe_ok) | (branch & taken));
  assign ir_write   = run & ir_write_raw & strobe_ok;
  assign retire     = run & retire_raw & strobe_ok;
  assign adr_src    = run & adr_src_raw;
  assign mem_write  = run & mem_write_raw;
  assign reg_write  = run & reg_write_raw;
  assign mem_req    = run & mem_req_raw;
  assign illegal    = run & illegal_raw;
  assign alu_src_a  = {2{run}} & alu_src_a_raw;
  assign alu_src_b  = {2{run}} & alu_src_b_raw;
  assign result_src = {2{run}} & result_src_raw;
  assign alu_op     = {2{run}} & alu_op_raw;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed per-cycle checks of the multicycle controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic       mem_req, illegal, retire;
  logic [15:0] obs;
  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src), .mem_write(mem_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_op(alu_op), .mem_req(mem_req), .illegal(illegal),
    .retire(retire)
  );

  always #5 clk = ~clk;

  // {pc_write,ir_write,adr_src,mem_write,reg_write}_{src_a}_{src_b}_{result_src}_{alu_op}_{mem_req,illegal,retire}
  assign obs = {pc_write, ir_write, adr_src, mem_write, reg_write, alu_src_a, alu_src_b,
                result_src, alu_op, mem_req, illegal, retire};

  localparam logic [15:0] E_RST     = 16'b00000_00_00_00_00_000;
  localparam logic [15:0] E_FETCH   = 16'b11000_00_10_10_00_100;
  localparam logic [15:0] E_FETCHW  = 16'b00000_00_10_10_00_100;
  localparam logic [15:0] E_DECODE  = 16'b00000_01_01_00_00_000;
  localparam logic [15:0] E_DECILL  = 16'b00000_01_01_00_00_010;
  localparam logic [15:0] E_EXECR   = 16'b00000_10_00_00_10_000;
  localparam logic [15:0] E_EXECI   = 16'b00000_10_01_00_10_000;
  localparam logic [15:0] E_ALUWB   = 16'b00001_00_00_00_00_001;
  localparam logic [15:0] E_MEMADR  = 16'b00000_10_01_00_00_000;
  localparam logic [15:0] E_MEMRD   = 16'b00100_00_00_00_00_100;
  localparam logic [15:0] E_MEMWB   = 16'b00001_00_00_01_00_001;
  localparam logic [15:0] E_MEMWR   = 16'b00110_00_00_00_00_101;
  localparam logic [15:0] E_MEMWRW  = 16'b00110_00_00_00_00_100;
  localparam logic [15:0] E_JAL     = 16'b10000_01_10_00_00_000;
  localparam logic [15:0] E_BEQT    = 16'b10000_10_00_00_01_001;
  localparam logic [15:0] E_BEQN    = 16'b00000_10_00_00_01_001;

  // input vector: {rst, mem_ready, zero, funct3, op}
  task automatic test_reset();
    logic [12:0] vin [3] = '{13'b1_1_0_000_0000011, 13'b1_1_1_001_1100011, 13'b1_0_0_000_0000000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); {rst, mem_ready, zero, funct3, op} = vin[i]; #1;
      checks++;
      if (obs !== E_RST) begin
        errors++; $display("FAIL reset cycle %0d got %b expected %b", i, obs, E_RST);
      end
    end
  endtask

  task automatic test_rtype();
    logic [12:0] vin [4];
    logic [15:0] vexp [4] = '{E_FETCH, E_DECODE, E_EXECR, E_ALUWB};
    for (int i = 0; i < 4; i++) vin[i] = 13'b0_1_0_000_0110011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); {rst, mem_ready, zero, funct3, op} = vin[i]; #1;
      checks++;
      if (obs !== vexp[i]) begin
        errors++; $display("FAIL rtype cycle %0d got %b expected %b", i, obs, vexp[i]);
      end
    end
  endtask

  task automatic test_itype_ready_ignored();
    logic [12:0] vin [4] = '{13'b0_1_0_000_0010011, 13'b0_0_0_000_0010011,
                             13'b0_0_1_000_0010011, 13'b0_0_0_000_0010011};
    logic [15:0] vexp [4] = '{E_FETCH, E_DECODE, E_EXECI, E_ALUWB};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); {rst, mem_ready, zero, funct3, op} = vin[i]; #1;
      checks++;
      if (obs !== vexp[i]) begin
        errors++; $display("FAIL itype cycle %0d got %b expected %b", i, obs, vexp[i]);
      end
    end
  endtask

  task automatic test_lw_stall();
    logic [12:0] vin [8] = '{13'b0_0_0_010_0000011, 13'b0_0_0_010_0000011,
                             13'b0_1_0_010_0000011, 13'b0_1_0_010_0000011,
                             13'b0_1_0_010_0000011, 13'b0_0_0_010_0000011,
                             13'b0_1_0_010_0000011, 13'b0_1_0_010_0000011};
    logic [15:0] vexp [8] = '{E_FETCHW, E_FETCHW, E_FETCH, E_DECODE,
                              E_MEMADR, E_MEMRD, E_MEMRD, E_MEMWB};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); {rst, mem_ready, zero, funct3, op} = vin[i]; #1;
      checks++;
      if (obs !== vexp[i]) begin
        errors++; $display("FAIL lw cycle %0d got %b expected %b", i, obs, vexp[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [12:0] vin [12] = '{13'b0_1_1_000_1100011, 13'b0_1_1_000_1100011, 13'b0_1_1_000_1100011,
                              13'b0_1_0_000_1100011, 13'b0_1_0_000_1100011, 13'b0_1_0_000_1100011,
                              13'b0_1_0_001_1100011, 13'b0_1_0_001_1100011, 13'b0_1_0_001_1100011,
                              13'b0_1_1_001_1100011, 13'b0_1_1_001_1100011, 13'b0_1_1_001_1100011};
    logic [15:0] vexp [12] = '{E_FETCH, E_DECODE, E_BEQT,
                               E_FETCH, E_DECODE, E_BEQN,
                               E_FETCH, E_DECODE, E_BEQT,
                               E_FETCH, E_DECODE, E_BEQN};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); {rst, mem_ready, zero, funct3, op} = vin[i]; #1;
      checks++;
      if (obs !== vexp[i]) begin
        errors++; $display("FAIL branch cycle %0d got %b expected %b", i, obs, vexp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [12:0] vin [4] = '{13'b0_1_0_000_1111111, 13'b0_1_0_000_1111111,
                             13'b0_0_0_000_1111111, 13'b0_0_0_000_1111111};
    logic [15:0] vexp [4] = '{E_FETCH, E_DECILL, E_FETCHW, E_FETCHW};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); {rst, mem_ready, zero, funct3, op} = vin[i]; #1;
      checks++;
      if (obs !== vexp[i]) begin
        errors++; $display("FAIL illegal cycle %0d got %b expected %b", i, obs, vexp[i]);
      end
    end
  endtask

  task automatic test_sw_reset_abort();
    logic [12:0] vin [11] = '{13'b0_1_0_010_0100011, 13'b0_1_0_010_0100011,
                              13'b0_1_0_010_0100011, 13'b0_0_0_010_0100011,
                              13'b1_0_0_010_0100011, 13'b0_0_0_010_0100011,
                              13'b0_0_0_010_0100011, 13'b0_1_0_010_0100011,
                              13'b0_1_0_010_0100011, 13'b0_1_0_010_0100011,
                              13'b0_1_0_010_0100011};
    logic [15:0] vexp [11] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWRW,
                               E_RST, E_FETCHW, E_FETCHW, E_FETCH,
                               E_DECODE, E_MEMADR, E_MEMWR};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); {rst, mem_ready, zero, funct3, op} = vin[i]; #1;
      checks++;
      if (obs !== vexp[i]) begin
        errors++; $display("FAIL sw_abort cycle %0d got %b expected %b", i, obs, vexp[i]);
      end
    end
  endtask

  task automatic test_back_to_back_jal();
    logic [12:0] vin [8];
    logic [15:0] vexp [8] = '{E_FETCH, E_DECODE, E_JAL, E_ALUWB,
                              E_FETCH, E_DECODE, E_JAL, E_ALUWB};
    for (int i = 0; i < 8; i++) vin[i] = 13'b0_1_0_000_1101111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); {rst, mem_ready, zero, funct3, op} = vin[i]; #1;
      checks++;
      if (obs !== vexp[i]) begin
        errors++; $display("FAIL jal cycle %0d got %b expected %b", i, obs, vexp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype_ready_ignored();
    test_lw_stall();
    test_branch();
    test_illegal();
    test_sw_reset_abort();
    test_back_to_back_jal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
